// File: rtl/selector_run_ctrl.sv
// selector_run_ctrl
// Run/stop controller for the 7-channel rolling selector. Debounces the
// per-channel stop buttons and the start button, drives the sequencer run
// enables (flag) and forces an auto-stop of the highest running channel
// when no stop has been accepted for TIMEOUT clocks.
module selector_run_ctrl #(
  parameter int NCH        = 7,
  parameter int DEB_CYCLES = 1000000,
  parameter int TIMEOUT    = 500000000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] btn,
  input  logic           btn_start,
  output logic [NCH-1:0] flag,
  output logic [NCH-1:0] stop_evt,
  output logic           busy,
  output logic           done,
  output logic [2:0]     last_ch
);

  // Button index NCH is the start button; 0..NCH-1 are the stop buttons.
  localparam int NB = NCH + 1;
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ROLLING = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Input conditioning registers
  logic [NB-1:0] r_sync1;
  logic [NB-1:0] r_sync2;
  logic [NB-1:0] r_deb;
  logic [NB-1:0] r_deb_d;
  logic [NB-1:0] r_press;
  logic [DW-1:0] r_cnt [NB];

  // Control registers
  state_t         r_state;
  logic [NCH-1:0] r_flag;
  logic [NCH-1:0] r_evt;
  logic [2:0]     r_last;
  logic [TW-1:0]  r_timer;

  // Next-state wires
  state_t         w_state_n;
  logic [NCH-1:0] w_flag_n;
  logic [NCH-1:0] w_evt_n;
  logic [2:0]     w_last_n;
  logic [TW-1:0]  w_timer_n;

  logic [NB-1:0]  w_raw;
  logic [NCH-1:0] w_press_stop;
  logic           w_press_start;
  logic [NCH-1:0] w_manual;
  logic [NCH-1:0] w_auto;
  logic [NCH-1:0] w_clear;
  logic [2:0]     w_low;

  assign w_raw         = {btn_start, btn};
  assign w_press_stop  = r_press[NCH-1:0];
  assign w_press_start = r_press[NCH];

  // Synchronise, debounce and edge-detect every button. A change of the
  // synchronised value back to the debounced level lands in the equality
  // clause, so the counter only ever runs across an unbroken mismatch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      r_press <= '0;
      for (int i = 0; i < NB; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      r_press <= r_deb & ~r_deb_d;
      for (int i = 0; i < NB; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DEB_MAX) begin
          r_deb[i] <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Pick the channels to freeze this cycle: manual presses on running
  // channels plus the timeout victim, and the lowest index among them.
  always_comb begin
    w_manual = w_press_stop & r_flag;
    w_auto   = '0;
    if (r_timer == TO_MAX) begin
      for (int i = 0; i < NCH; i++) begin
        if (r_flag[i]) w_auto = NCH'(1) << i;
      end
    end
    w_clear = w_manual | w_auto;
    w_low   = 3'd0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (w_clear[i]) w_low = 3'(i);
    end
  end

  // Control state register: FSM state, run enables, event pulses, timer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_flag  <= '0;
      r_evt   <= '0;
      r_last  <= 3'd0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_n;
      r_flag  <= w_flag_n;
      r_evt   <= w_evt_n;
      r_last  <= w_last_n;
      r_timer <= w_timer_n;
    end
  end

  // Next-state logic: start a round, apply stops, detect round completion.
  always_comb begin
    w_state_n = r_state;
    w_flag_n  = r_flag;
    w_evt_n   = '0;
    w_last_n  = r_last;
    w_timer_n = r_timer;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_press_start) begin
          w_state_n = ST_ROLLING;
          w_flag_n  = '1;
          w_timer_n = '0;
        end
      end
      ST_ROLLING: begin
        if (w_clear != '0) begin
          w_flag_n  = r_flag & ~w_clear;
          w_evt_n   = w_clear;
          w_last_n  = w_low;
          w_timer_n = '0;
          if ((r_flag & ~w_clear) == '0) w_state_n = ST_DONE;
        end else begin
          w_timer_n = r_timer + TW'(1);
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        w_flag_n  = '0;
      end
    endcase
  end

  // Output decode straight from registered state.
  always_comb begin
    busy     = (r_state == ST_ROLLING);
    done     = (r_state == ST_DONE);
    flag     = r_flag;
    stop_evt = r_evt;
    last_ch  = r_last;
  end

endmodule

// File: tb/tb_selector_run_ctrl.sv
// tb_selector_run_ctrl
// Directed sequence with randomised orders, hold times and gaps, checked
// against a round-level model of the selector (running set, last stop).
module tb_selector_run_ctrl;

  localparam int NCH = 7;
  localparam int DEB = 4;
  localparam int TO  = 64;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NCH-1:0] btn = '0;
  logic           btn_start = 1'b0;
  logic [NCH-1:0] flag;
  logic [NCH-1:0] stop_evt;
  logic           busy;
  logic           done;
  logic [2:0]     last_ch;

  selector_run_ctrl #(
    .NCH(NCH), .DEB_CYCLES(DEB), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn), .btn_start(btn_start),
    .flag(flag), .stop_evt(stop_evt), .busy(busy), .done(done),
    .last_ch(last_ch)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Round-level model
  logic [6:0] m_flag = '0;
  logic [2:0] m_last = '0;
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;

  function automatic logic [2:0] lowest_idx(input logic [6:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 6; i >= 0; i--) if (m[i]) r = 3'(i);
    return r;
  endfunction

  function automatic logic [6:0] highest_bit(input logic [6:0] m);
    logic [6:0] r;
    r = '0;
    for (int i = 0; i < 7; i++) if (m[i]) r = 7'(1) << i;
    return r;
  endfunction

  task automatic model_reset();
    m_flag = '0; m_last = '0; m_busy = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_start();
    if (!m_busy) begin
      m_flag = 7'h7F; m_busy = 1'b1; m_done = 1'b0;
    end
  endtask

  task automatic model_stop(input logic [6:0] m, output logic [6:0] evt);
    evt = m_busy ? (m & m_flag) : 7'h00;
    if (evt != 7'h00) begin
      m_flag = m_flag & ~evt;
      m_last = lowest_idx(evt);
      if (m_flag == 7'h00) begin
        m_busy = 1'b0; m_done = 1'b1;
      end
    end
  endtask

  // Scoreboard compare
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_all(input string tag, input logic [6:0] exp_evt);
    chk({tag, ".flag"}, 32'(flag), 32'(m_flag));
    chk({tag, ".stop_evt"}, 32'(stop_evt), 32'(exp_evt));
    chk({tag, ".last_ch"}, 32'(last_ch), 32'(m_last));
    chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
    chk({tag, ".done"}, 32'(done), 32'(m_done));
  endtask

  // Driver: press at a negedge, hold for 'hold' clocks (>=5). The debounced
  // press acts on the 8th edge; returns at the negedge after max(hold,9).
  task automatic press(input logic is_start, input logic [6:0] mask,
                       input int hold, input string tag);
    logic [6:0] evt;
    int last_k;
    last_k = (hold > 9) ? hold : 9;
    if (is_start) btn_start = 1'b1; else btn = mask;
    for (int k = 1; k <= last_k; k++) begin
      @(negedge clk);
      if (k == hold) begin btn = '0; btn_start = 1'b0; end
      if (k == 7) check_all({tag, ".pre"}, 7'h00);
      if (k == 8) begin
        if (is_start) begin model_start(); evt = 7'h00; end
        else model_stop(mask, evt);
        check_all(tag, evt);
      end
      if (k == 9) chk({tag, ".evt_end"}, 32'(stop_evt), 32'd0);
    end
  endtask

  task automatic settle(input int n, input string tag);
    repeat (n) @(negedge clk);
    check_all(tag, 7'h00);
  endtask

  initial begin
    int ord [7];
    int pos;
    int r;
    int tmp;
    int j;
    int guard;
    logic [6:0] evt;
    logic [6:0] mask;

    // Reset state, asynchronous
    #2 rst = 1'b0;
    #1 check_all("reset", 7'h00);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    settle(2, "idle");

    // Stop press while idle is ignored
    press(1'b0, 7'h01, 6, "idle_stop");
    settle(7, "idle_stop.after");

    // Start: 10-clock hold, round begins; release does nothing
    press(1'b1, 7'h00, 10, "start");

    // Bounce on btn[3] right away; never accepted
    for (int i = 0; i < 20; i++) begin
      btn[3] = ~btn[3];
      repeat (2) @(negedge clk);
      chk("bounce.evt", 32'(stop_evt), 32'd0);
      chk("bounce.flag", 32'(flag), 32'(m_flag));
    end
    btn = '0;
    settle(6, "bounce.after");
    chk("bounce.flag3", 32'(flag[3]), 32'd1);

    // Stop every channel one at a time, random order
    for (int i = 0; i < 7; i++) ord[i] = i;
    for (int i = 6; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
    end
    for (int i = 0; i < 7; i++) begin
      press(1'b0, 7'(1) << ord[i], int'($urandom_range(5, 12)), "stop_one");
      chk("stop_one.last_ch", 32'(last_ch), 32'(ord[i]));
      settle(int'($urandom_range(7, 14)), "stop_one.gap");
    end
    chk("all_done", 32'(done), 32'd1);

    // New round, simultaneous stop, repeat stop, start while rolling
    press(1'b1, 7'h00, int'($urandom_range(5, 9)), "restart");
    settle(7, "restart.gap");
    press(1'b0, 7'h24, 6, "simul");
    chk("simul.flag_const", 32'(flag), 32'h5B);
    settle(7, "simul.gap");
    press(1'b0, 7'h04, 6, "repress");
    settle(7, "repress.gap");
    press(1'b1, 7'h00, 6, "start_in_run");
    settle(7, "start_in_run.gap");
    guard = 0;
    while (m_busy && guard < 20) begin
      mask = 7'($urandom_range(1, 127));
      if ((mask & m_flag) == 7'h00) mask = mask | highest_bit(m_flag);
      press(1'b0, mask, int'($urandom_range(5, 8)), "rand_stop");
      settle(7, "rand_stop.gap");
      guard++;
    end
    chk("rand_done", 32'(done), 32'd1);

    // Auto-stop: one channel per TO clocks, highest first
    press(1'b1, 7'h00, 6, "to_start");
    pos = 1;
    for (int k = 1; k <= 7; k++) begin
      repeat (TO * k - 1 - pos) @(negedge clk);
      check_all("to_pre", 7'h00);
      @(negedge clk);
      model_stop(highest_bit(m_flag), evt);
      check_all("to_fire", evt);
      pos = TO * k;
    end
    chk("to_done", 32'(done), 32'd1);
    press(1'b1, 7'h00, 6, "to_restart");
    chk("to_restart.flag_const", 32'(flag), 32'h7F);

    // A manual stop restarts the auto-stop interval
    r = int'($urandom_range(5, 30));
    repeat (r) @(negedge clk);
    press(1'b0, 7'h25, 6, "mid_stop");
    chk("mid_stop.flag_const", 32'(flag), 32'h5A);
    repeat (62) @(negedge clk);
    check_all("tc_pre", 7'h00);
    @(negedge clk);
    model_stop(highest_bit(m_flag), evt);
    check_all("tc_fire", evt);

    // Reset mid-round, away from the clock edge
    #2 rst = 1'b0;
    model_reset();
    #1 check_all("rst_a", 7'h00);
    @(negedge clk); rst = 1'b1;
    settle(3, "rst_a.after");

    // Reset with flag = 5A
    press(1'b1, 7'h00, 6, "rst_b_start");
    settle(7, "rst_b.gap");
    press(1'b0, 7'h25, 6, "rst_b_stop");
    chk("rst_b.flag_const", 32'(flag), 32'h5A);
    #2 rst = 1'b0;
    model_reset();
    #1 check_all("rst_b", 7'h00);
    @(negedge clk); rst = 1'b1;
    settle(3, "rst_b.after");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
